// File: rtl/sum_latch_uart_framer.sv
// Operand latch with add/subtract result register. Each new result is sent once
// as an uppercase ASCII hex frame (digits, CR, LF) through a handshaked byte UART.
module sum_latch_uart_framer #(
  parameter int DATA_W  = 4,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_a_n,
  input  logic              save_b_n,
  input  logic [DATA_W-1:0] data_input,
  input  logic              op_sub,
  input  logic              uart_tx_busy,
  output logic              uart_tx_en,
  output logic [7:0]        uart_tx_data,
  output logic [DATA_W:0]   result,
  output logic              frame_busy
);

  localparam int RES_W = DATA_W + 1;
  localparam int NDIG  = (RES_W + 3) / 4;
  localparam int SH_W  = 4 * NDIG;
  localparam int IDX_W = $clog2(NDIG + 2) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  logic a_s, b_s;
  logic a_prev, b_prev;
  logic a_fall, b_fall;

  // Synchronisers reset to the inactive (high) level so reset never fakes a save.
  if (SYNC_EN) begin : g_sync2
    logic [1:0] a_ff, b_ff;
    always_ff @(posedge clk) begin
      if (reset) begin
        a_ff <= '1;
        b_ff <= '1;
      end else begin
        a_ff <= {a_ff[0], save_a_n};
        b_ff <= {b_ff[0], save_b_n};
      end
    end
    assign a_s = a_ff[1];
    assign b_s = b_ff[1];
  end else begin : g_sync1
    logic a_ff, b_ff;
    always_ff @(posedge clk) begin
      if (reset) begin
        a_ff <= 1'b1;
        b_ff <= 1'b1;
      end else begin
        a_ff <= save_a_n;
        b_ff <= save_b_n;
      end
    end
    assign a_s = a_ff;
    assign b_s = b_ff;
  end

  assign a_fall = a_prev & ~a_s;
  assign b_fall = b_prev & ~b_s;

  logic [DATA_W-1:0] opa, opb;
  logic              op;
  logic              upd;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_prev <= 1'b1;
      b_prev <= 1'b1;
      opa    <= '0;
      opb    <= '0;
      op     <= 1'b0;
      upd    <= 1'b0;
    end else begin
      a_prev <= a_s;
      b_prev <= b_s;
      upd    <= a_fall | b_fall;
      if (a_fall) opa <= data_input;
      if (b_fall) opb <= data_input;
      if (a_fall | b_fall) op <= op_sub;
    end
  end

  state_t            state;
  logic              pending;
  logic [SH_W-1:0]   snap;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        nib;
  logic [7:0]        cur_byte;

  always_comb begin
    nib = snap[SH_W-1 -: 4];
    if (idx < IDX_W'(NDIG))
      cur_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    else if (idx == IDX_W'(NDIG))
      cur_byte = 8'h0D;
    else
      cur_byte = 8'h0A;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      result       <= '0;
      pending      <= 1'b0;
      snap         <= '0;
      idx          <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      frame_busy   <= 1'b0;
    end else begin
      uart_tx_en <= 1'b0;
      if (upd)
        result <= op ? ({1'b0, opa} - {1'b0, opb}) : ({1'b0, opa} + {1'b0, opb});

      case (state)
        S_IDLE: begin
          if (pending) begin
            pending <= 1'b0;
            snap    <= SH_W'(result);
            idx     <= '0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          frame_busy <= 1'b1;
          state      <= S_REQ;
        end
        S_REQ: begin
          if (!uart_tx_busy) begin
            uart_tx_en   <= 1'b1;
            uart_tx_data <= cur_byte;
            state        <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (uart_tx_busy) state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!uart_tx_busy) begin
            if (idx == IDX_W'(NDIG + 1)) begin
              frame_busy <= 1'b0;
              state      <= S_IDLE;
            end else begin
              idx   <= idx + 1'b1;
              snap  <= snap << 4;
              state <= S_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // A result landing in the same cycle the FSM leaves IDLE is not in the
      // snapshot, so the set must win over the clear.
      if (upd) pending <= 1'b1;
    end
  end

endmodule
